// File: rtl/reg_file_pkg.sv
// Shared defaults and update-priority helper for the register file.
package reg_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_PC_IDX  = 15;
  localparam int DEF_PC_STEP = 4;
  localparam int DEF_BYPASS  = 1;

  // What a single register slot does on an enabled clock edge.
  typedef enum logic [1:0] {
    UPD_HOLD  = 2'd0,
    UPD_INC   = 2'd1,
    UPD_WRITE = 2'd2,
    UPD_CLEAR = 2'd3
  } upd_sel_e;

  // Clear beats write, write beats PC increment, otherwise hold.
  function automatic upd_sel_e resolve_update(input logic clr_hit,
                                              input logic wr_hit,
                                              input logic inc_en);
    if (clr_hit)     return UPD_CLEAR;
    else if (wr_hit) return UPD_WRITE;
    else if (inc_en) return UPD_INC;
    else             return UPD_HOLD;
  endfunction

endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: select mux, optional write/clear bypass,
// and operand-ready flag derived from the busy scoreboard.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BYPASS = DEF_BYPASS,
  localparam int DEPTH = 2 ** ADDR_W
) (
  input  logic [DATA_W-1:0] i_regs [DEPTH],
  input  logic [DEPTH-1:0]  i_busy,
  input  logic [ADDR_W-1:0] i_sel,
  input  logic              i_byp_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wsel,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_ce,
  input  logic [ADDR_W-1:0] i_csel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rdy
);

  logic w_clr_hit;
  logic w_wr_hit;

  // A pending clear shadows a pending write to the same register.
  assign w_clr_hit = (BYPASS != 0) && i_byp_en && i_ce && (i_csel == i_sel);
  assign w_wr_hit  = (BYPASS != 0) && i_byp_en && i_we && (i_wsel == i_sel);

  // Data and ready: a bypass hit means the operand is being produced now.
  always_comb begin
    o_data = i_regs[i_sel];
    o_rdy  = ~i_busy[i_sel];
    if (w_clr_hit) begin
      o_data = '0;
      o_rdy  = 1'b1;
    end else if (w_wr_hit) begin
      o_data = i_din;
      o_rdy  = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with one write port, one clear port, two read ports,
// an auto-incrementing PC slot and a per-register busy scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PC_IDX  = DEF_PC_IDX,
  parameter int PC_STEP = DEF_PC_STEP,
  parameter int BYPASS  = DEF_BYPASS
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RFE,
  input  logic              WE,
  input  logic [ADDR_W-1:0] RC,
  input  logic [DATA_W-1:0] DIN,
  input  logic              CE,
  input  logic [ADDR_W-1:0] RD,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic              ISSUE,
  input  logic [ADDR_W-1:0] ISSUE_IDX,
  input  logic              PC_HOLD,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              A_RDY,
  output logic              B_RDY,
  output logic [DATA_W-1:0] PC
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  logic [DATA_W-1:0] r_regs     [DEPTH];
  logic [DATA_W-1:0] w_reg_nxt  [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_byp_en;

  // Per-slot next value and busy bit; issue overrides write/clear on busy
  // because the newly issued producer supersedes the completing one.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
    logic     w_clr_hit;
    logic     w_wr_hit;
    logic     w_inc_en;
    logic     w_iss_hit;
    upd_sel_e w_sel;

    assign w_clr_hit = CE && (RD == IDX);
    assign w_wr_hit  = WE && (RC == IDX);
    assign w_inc_en  = (g == PC_IDX) && !PC_HOLD;
    assign w_iss_hit = ISSUE && (ISSUE_IDX == IDX);
    assign w_sel     = resolve_update(w_clr_hit, w_wr_hit, w_inc_en);

    assign w_reg_nxt[g] = (w_sel == UPD_CLEAR) ? '0 :
                          (w_sel == UPD_WRITE) ? DIN :
                          (w_sel == UPD_INC)   ? r_regs[g] + STEP :
                                                 r_regs[g];

    assign w_busy_nxt[g] = w_iss_hit ? 1'b1 :
                           (w_clr_hit || w_wr_hit) ? 1'b0 : r_busy[g];
  end

  // Storage and scoreboard; RFE high freezes everything including PC.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_regs <= '{default: '0};
      r_busy <= '0;
    end else if (!RFE) begin
      r_regs <= w_reg_nxt;
      r_busy <= w_busy_nxt;
    end
  end

  // Bypass only when this cycle's update will actually land; suppressed
  // under reset so outputs read as cleared while reset is held.
  assign w_byp_en = ~RFE & RESET_N;

  assign PC = r_regs[PC_IDX];

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .i_regs   (r_regs),
    .i_busy   (r_busy),
    .i_sel    (RA),
    .i_byp_en (w_byp_en),
    .i_we     (WE),
    .i_wsel   (RC),
    .i_din    (DIN),
    .i_ce     (CE),
    .i_csel   (RD),
    .o_data   (A),
    .o_rdy    (A_RDY)
  );

  reg_file_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .i_regs   (r_regs),
    .i_busy   (r_busy),
    .i_sel    (RB),
    .i_byp_en (w_byp_en),
    .i_we     (WE),
    .i_wsel   (RC),
    .i_din    (DIN),
    .i_ce     (CE),
    .i_csel   (RD),
    .o_data   (B),
    .o_rdy    (B_RDY)
  );

endmodule
